// File: rtl/sdram_rd_stream.sv
// Purpose: streams one frame of FRAME_BYTES bytes from an SDRAM read-port FIFO into a valid/ready byte stream (build option: RD_STREAM_ABORT_EN).
// Latency: LOAD_CYC + WAIT_CYC clocks of setup, then first m_valid two clocks after the first rd_en; one byte per clock when m_ready stays high.
// Backpressure: a 2-entry output buffer; rd_en is only issued when the buffered plus in-flight bytes, less this cycle's pop, are below 2.
module sdram_rd_stream #(
    parameter int FRAME_BYTES = 4096,
    parameter int LOAD_CYC    = 4,
    parameter int WAIT_CYC    = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sdram_init_done,
    input  logic       frame_start,
    output logic       rd_load,
    output logic       sdram_read_valid,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [15:0] FRAME_LEN = 16'(FRAME_BYTES);
    localparam logic [15:0] LAST_IDX  = 16'(FRAME_BYTES - 1);
    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYC - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);

    state_t          state_q, state_d;
    logic [15:0]     load_cnt_q, load_cnt_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic [15:0]     issued_q, issued_d;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic            inflight_q, inflight_d;
    logic [1:0][7:0] buf_dat_q, buf_dat_d;
    logic [1:0]      buf_last_q, buf_last_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      occ_q, occ_d;

    logic            start_ok;
    logic            abort_c;
    logic            pop_c;
    logic            rd_en_c;
    logic            frame_done_c;
    logic            load_entry;
    logic [2:0]      need_c;
    logic [2:0]      room_c;

    assign start_ok = frame_start && sdram_init_done;
    assign pop_c    = (occ_q != 2'd0) && m_ready;

`ifdef RD_STREAM_ABORT_EN
    // A new request while a frame is being fetched restarts from LOAD.
    assign abort_c = start_ok && (state_q inside {S_WAIT, S_STREAM, S_DRAIN});
`else
    assign abort_c = 1'b0;
`endif

    // Bytes already owed to the buffer versus the space left after this cycle's pop.
    assign need_c  = {1'b0, occ_q} + {2'b00, inflight_q};
    assign room_c  = 3'd2 + {2'b00, pop_c};
    assign rd_en_c = (state_q == S_STREAM) && (issued_q < FRAME_LEN) &&
                     (need_c < room_c) && !abort_c;

    assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

    // Frame sequencing: next state, setup counters and the issued-byte count.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        issued_d     = issued_q;
        frame_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_cnt_q == LOAD_LAST) state_d = S_WAIT;
                else                         load_cnt_d = load_cnt_q + 16'd1;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = S_STREAM;
                else                         wait_cnt_d = wait_cnt_q + 16'd1;
            end
            S_STREAM: begin
                if (rd_en_c) begin
                    issued_d = issued_q + 16'd1;
                    if (issued_q == LAST_IDX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d      = S_IDLE;
                    frame_done_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_c) begin
            state_d      = S_LOAD;
            frame_done_c = 1'b0;
        end
        if (load_entry) begin
            load_cnt_d = '0;
            wait_cnt_d = '0;
            issued_d   = '0;
        end
    end

    // Output buffer: capture the byte one clock after rd_en, pop on handshake, flush on restart.
    always_comb begin
        buf_dat_d  = buf_dat_q;
        buf_last_d = buf_last_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        wr_cnt_d   = wr_cnt_q;
        inflight_d = rd_en_c;
        if (abort_c) begin
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (inflight_q) begin
                buf_dat_d[wr_ptr_q]  = rd_data;
                buf_last_d[wr_ptr_q] = (wr_cnt_q == LAST_IDX);
                wr_ptr_d             = ~wr_ptr_q;
                wr_cnt_d             = wr_cnt_q + 16'd1;
            end
            if (pop_c) rd_ptr_d = ~rd_ptr_q;
            occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop_c};
        end
        if (load_entry) wr_cnt_d = '0;
    end

    // State and datapath registers with synchronous reset; a byte in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            wait_cnt_q <= '0;
            issued_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            buf_dat_q  <= '0;
            buf_last_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            issued_q   <= issued_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            buf_dat_q  <= buf_dat_d;
            buf_last_q <= buf_last_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
        end
    end

    assign rd_load          = (state_q == S_LOAD);
    assign sdram_read_valid = (state_q inside {S_WAIT, S_STREAM, S_DRAIN});
    assign rd_en            = rd_en_c;
    assign busy             = (state_q != S_IDLE);
    assign frame_done       = frame_done_c;
    assign m_valid          = (occ_q != 2'd0);
    assign m_data           = m_valid ? buf_dat_q[rd_ptr_q] : 8'd0;
    assign m_last           = m_valid && buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_sdram_rd_stream.sv
// Purpose: self-checking bench for sdram_rd_stream (16-byte frames, plus a 1-byte-frame instance).
// Latency: bytes are supplied one clock after each rd_en, like the real read-port FIFO.
// Backpressure: m_ready driven constant, 1-0-0-1 pattern or random per frame.
module tb_sdram_rd_stream;

    localparam int FB = 16;
    localparam int LC = 4;
    localparam int WC = 256;
`ifdef RD_STREAM_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, sdram_init_done = 1'b0, frame_start = 1'b0, m_ready = 1'b1;
    logic [7:0] rd_data = 8'd0;
    logic       rd_load, sdram_read_valid, rd_en, m_valid, m_last, busy, frame_done;
    logic [7:0] m_data;

    logic       frame_start1 = 1'b0, m_ready1 = 1'b1;
    logic [7:0] rd_data1 = 8'd0;
    logic       rd_load1, srv1, rd_en1, m_valid1, m_last1, busy1, frame_done1;
    logic [7:0] m_data1;

    sdram_rd_stream #(.FRAME_BYTES(FB), .LOAD_CYC(LC), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .frame_start(frame_start),
        .rd_load(rd_load), .sdram_read_valid(sdram_read_valid), .rd_en(rd_en), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .frame_done(frame_done)
    );

    sdram_rd_stream #(.FRAME_BYTES(1), .LOAD_CYC(2), .WAIT_CYC(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .frame_start(frame_start1),
        .rd_load(rd_load1), .sdram_read_valid(srv1), .rd_en(rd_en1), .rd_data(rd_data1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1),
        .busy(busy1), .frame_done(frame_done1)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    int   n_cmp = 0, n_bad = 0;
    exp_t exp_q[$];
    int   sup_idx = 0, cyc = 0, rmode = 0;
    bit   pend_vld = 0, pend1 = 0, flush_now = 0, flush_last = 0;
    logic [7:0] pend_byte = 0, pend1_byte = 0, exp1 = 0;
    bit   rst_req = 0, fs_req = 0, init_req = 0, fs1_req = 0, flush_req = 0;

    logic s_rd_load, s_srv, s_rd_en, s_mv, s_ml, s_busy, s_fd, s_pop;
    logic [7:0] s_md;
    logic s_mv1, s_ml1, s_fd1;
    logic [7:0] s_md1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: apply requested inputs at the falling edge, play the read-port FIFO, sample outputs.
    task automatic step();
        bit fl;
        @(negedge clk);
        cyc++;
        if (flush_last) begin
            exp_q.delete();
            sup_idx = 0;
        end
        rst_n           = rst_req;
        frame_start     = fs_req;
        sdram_init_done = init_req;
        frame_start1    = fs1_req;
        fl              = flush_req || !rst_req;
        flush_now       = fl;
        if (pend_vld) begin
            rd_data = pend_byte;
            exp_q.push_back('{d: pend_byte, l: (sup_idx == FB - 1)});
            sup_idx++;
        end else begin
            rd_data = 8'($urandom);
        end
        if (pend1) begin
            rd_data1 = pend1_byte;
            exp1     = pend1_byte;
        end else begin
            rd_data1 = 8'($urandom);
        end
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        s_rd_load = rd_load;  s_srv = sdram_read_valid;  s_rd_en = rd_en;
        s_mv = m_valid;  s_ml = m_last;  s_md = m_data;  s_busy = busy;  s_fd = frame_done;
        s_pop = m_valid && m_ready;
        s_mv1 = m_valid1;  s_ml1 = m_last1;  s_md1 = m_data1;  s_fd1 = frame_done1;
        pend_vld   = (rd_en === 1'b1) && !fl;
        pend_byte  = 8'($urandom);
        pend1      = (rd_en1 === 1'b1) && rst_req;
        pend1_byte = 8'($urandom);
        flush_last = fl;
    endtask

    // Scoreboard monitor: pops the expected byte on every accepted handshake.
    exp_t       e;
    bit         prev_stall = 0;
    logic [7:0] prev_d = 0;
    logic       prev_l = 0;
    always @(negedge clk) begin
        #2;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got byte %02h, required no byte (cycle %0d)", m_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(e.d));
                chk("m_last", 32'(m_last), 32'(e.l));
            end
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_d));
            chk("stall_last", 32'(m_last), 32'(prev_l));
        end
        if (busy === 1'b1) chk("occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0) && !flush_now;
        prev_d     = m_data;
        prev_l     = m_last;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_load"}, 32'(s_rd_load), 0);
        chk({tag, "_sdram_read_valid"}, 32'(s_srv), 0);
        chk({tag, "_rd_en"}, 32'(s_rd_en), 0);
        chk({tag, "_m_valid"}, 32'(s_mv), 0);
        chk({tag, "_m_last"}, 32'(s_ml), 0);
        chk({tag, "_m_data"}, 32'(s_md), 0);
        chk({tag, "_busy"}, 32'(s_busy), 0);
        chk({tag, "_frame_done"}, 32'(s_fd), 0);
    endtask

    // Full-rate frame: setup timing, stream cadence, m_last position and frame_done placement.
    task automatic frame_timing();
        int load_n = 0, last_load = -1, first_srv = -1, first_en = -1, first_v = -1;
        int pop_n = 0, last_pop = -1, gaps = 0, ml_n = 0, last_on = -1, fd_n = 0, fd_c = -1;
        sup_idx = 0; rmode = 0; init_req = 1; fs_req = 1;
        step();
        fs_req = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (s_rd_load) begin load_n++; last_load = cyc; end
            if (s_srv && first_srv < 0) first_srv = cyc;
            if (s_rd_en && first_en < 0) first_en = cyc;
            if (s_mv && first_v < 0) first_v = cyc;
            if (s_pop) begin
                if (pop_n > 0 && cyc != last_pop + 1) gaps++;
                if (s_ml) begin ml_n++; last_on = pop_n; end
                pop_n++;
                last_pop = cyc;
            end
            if (s_fd) begin fd_n++; fd_c = cyc; end
            if (fd_c >= 0 && cyc >= fd_c + 3) break;
        end
        chk("load_cycles", 32'(load_n), LC);
        chk("read_valid_at_wait_entry", 32'(first_srv), 32'(last_load + 1));
        chk("first_rd_en_after_wait", 32'(first_en), 32'(last_load + WC + 1));
        chk("first_m_valid_latency", 32'(first_v - first_en), 2);
        chk("frame_byte_count", 32'(pop_n), FB);
        chk("stream_gaps", 32'(gaps), 0);
        chk("m_last_count", 32'(ml_n), 1);
        chk("m_last_index", 32'(last_on), FB - 1);
        chk("frame_done_count", 32'(fd_n), 1);
        chk("frame_done_after_last", 32'(fd_c), 32'(last_pop + 1));
        chk("idle_after_frame", 32'(s_busy), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
    endtask

    // ev_kind: 0 none, 1 one-clock reset after ev_at bytes, 2 new frame_start after ev_at bytes.
    task automatic run_frame(input int mode, input int ev_at, input int ev_kind);
        int pops = 0, pops_after = 0, fds = 0;
        bit fired = 0, done = 0, ev_now;
        sup_idx = 0; rmode = mode; init_req = 1; fs_req = 1;
        step();
        fs_req = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            ev_now = !fired && ev_at >= 0 && pops == ev_at;
            if (ev_now) begin
                fired = 1;
                if (ev_kind == 1) rst_req = 0;
                else begin
                    fs_req    = 1;
                    flush_req = ABORT;
                end
            end
            step();
            rst_req = 1; fs_req = 0; flush_req = 0;
            if (s_pop) begin pops++; if (fired && !ev_now) pops_after++; end
            if (s_fd) fds++;
            if (ev_now) begin
                step();
                if (ev_kind == 1) begin
                    chk_reset_outputs("mid_reset");
                    done = 1;
                end else begin
                    chk("restart_rd_load", 32'(s_rd_load), 32'(ABORT));
                    if (s_pop) begin pops++; pops_after++; end
                    if (s_fd) fds++;
                end
            end else if (!s_busy) begin
                done = 1;
            end
        end
        if (ev_kind == 1) begin
            step();
            chk("reset_scoreboard_empty", 32'(exp_q.size()), 0);
            chk("reset_stays_idle", 32'(s_busy), 0);
        end else begin
            if (ev_kind == 2) begin
`ifdef RD_STREAM_ABORT_EN
                chk("restart_frame_bytes", 32'(pops_after), FB);
`else
                chk("ignored_start_frame_bytes", 32'(pops), FB);
`endif
            end else begin
                chk("frame_bytes", 32'(pops), FB);
            end
            chk("frame_done_pulses", 32'(fds), 1);
            chk("frame_scoreboard_empty", 32'(exp_q.size()), 0);
            chk("frame_ends_idle", 32'(s_busy), 0);
        end
    endtask

    // FRAME_BYTES=1 instance: one byte carrying m_last, then frame_done.
    task automatic single_byte_frame();
        int v1_n = 0, v1_c = -1, fd1_n = 0, fd1_c = -1;
        logic l1 = 0;
        logic [7:0] d1 = 0;
        init_req = 1; fs1_req = 1;
        step();
        fs1_req = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (s_mv1) begin v1_n++; v1_c = cyc; l1 = s_ml1; d1 = s_md1; end
            if (s_fd1) begin fd1_n++; fd1_c = cyc; end
            if (fd1_c >= 0 && cyc > fd1_c + 2) break;
        end
        chk("fb1_valid_cycles", 32'(v1_n), 1);
        chk("fb1_last_with_valid", 32'(l1), 1);
        chk("fb1_data", 32'(d1), 32'(exp1));
        chk("fb1_frame_done_count", 32'(fd1_n), 1);
        chk("fb1_frame_done_time", 32'(fd1_c), 32'(v1_c + 1));
    endtask

    initial begin
        bit any_act;
        rst_req = 0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_req = 1;
        step();

        // Request without SDRAM ready must be ignored.
        init_req = 0; fs_req = 1;
        step();
        fs_req = 0;
        any_act = 0;
        repeat (20) begin
            step();
            if (s_busy !== 1'b0 || s_rd_load !== 1'b0) any_act = 1;
        end
        chk("start_without_init_ignored", 32'(any_act), 0);

        frame_timing();
        run_frame(1, -1, 0);
        for (int k = 0; k < 3; k++) run_frame(2, -1, 0);
        run_frame(0, 7, 1);
        run_frame(0, 5, 2);
        run_frame(2, 9, 2);
        run_frame(0, -1, 0);
        single_byte_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
